// File: rtl/wb_pkg.sv
// Shared types for the writeback/commit queue: the buffered instruction record
// and GPR/CSR field widths.
package wb_pkg;
  localparam int GPR_W      = 32;
  localparam int GPR_IDX_W  = 5;
  localparam int CSR_ADDR_W = 14;
  localparam int ECODE_W    = 8;

  typedef struct packed {
    logic [31:0]           pc;
    logic [GPR_W-1:0]      result;
    logic                  gr_we;
    logic [GPR_IDX_W-1:0]  dest;
    logic [31:0]           vaddr;
    logic                  ex;
    logic [ECODE_W-1:0]    ecode;
    logic                  esubcode;
    logic                  csr_we;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [31:0]           csr_wmask;
    logic [31:0]           csr_wdata;
  } wb_entry_t;

  function automatic logic [31:0] dest_onehot(input logic [GPR_IDX_W-1:0] d);
    return 32'(1) << d;
  endfunction
endpackage

// File: rtl/wb_commit_queue_if.sv
// Memory-stage -> commit-queue handshake bundle.
interface wb_commit_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_result;
  logic [31:0] in_vaddr;
  logic        in_gr_we;
  logic [4:0]  in_dest;
  logic        in_ex;
  logic [7:0]  in_ecode;
  logic        in_esubcode;
  logic        in_csr_we;
  logic [13:0] in_csr_addr;
  logic [31:0] in_csr_wmask;
  logic [31:0] in_csr_wdata;

  modport master (
    output in_valid, in_pc, in_result, in_vaddr, in_gr_we, in_dest, in_ex,
           in_ecode, in_esubcode, in_csr_we, in_csr_addr, in_csr_wmask, in_csr_wdata,
    input  in_ready
  );
  modport slave (
    input  in_valid, in_pc, in_result, in_vaddr, in_gr_we, in_dest, in_ex,
           in_ecode, in_esubcode, in_csr_we, in_csr_addr, in_csr_wmask, in_csr_wdata,
    output in_ready
  );
endinterface

// File: rtl/wb_queue.sv
// Circular buffer of wb_entry_t: one push per cycle, 0..RETIRE_W pops from the head,
// plus a per-entry view of pending GPR writes for the scoreboard.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RETIRE_W = 2,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int POP_W   = $clog2(RETIRE_W + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 enq,
  input  wb_entry_t                            enq_ent,
  input  logic [POP_W-1:0]                     pop_n,
  output wb_entry_t [RETIRE_W-1:0]             head_ent,
  output logic [DEPTH-1:0][GPR_IDX_W-1:0]      ent_dest,
  output logic [DEPTH-1:0]                     ent_wr,
  output logic [CNT_W-1:0]                     count
);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q + PTR_W'(pop_n);
    tail_d  = tail_q;
    count_d = count_q - CNT_W'(pop_n);
    if (enq) begin
      mem_d[tail_q] = enq_ent;
      tail_d        = tail_q + PTR_W'(1);
      count_d       = count_d + CNT_W'(1);
    end
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: nothing reads it while count is zero.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_comb begin
    logic [PTR_W-1:0] off;
    for (int k = 0; k < RETIRE_W; k++) head_ent[k] = mem_q[head_q + PTR_W'(k)];
    for (int i = 0; i < DEPTH; i++) begin
      off         = PTR_W'(i) - head_q;
      ent_dest[i] = mem_q[i].dest;
      ent_wr[i]   = (CNT_W'(off) < count_q) && mem_q[i].gr_we && !mem_q[i].ex;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/wb_commit_queue.sv
// In-order commit stage: retires up to RETIRE_W entries per cycle, serialises CSR
// writes and exceptions, and publishes a pending-destination scoreboard.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RETIRE_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  wb_commit_queue_if.slave        in_if,
  input  logic                    flush,
  output logic [RETIRE_W-1:0]     rf_we,
  output logic [5*RETIRE_W-1:0]   rf_waddr,
  output logic [32*RETIRE_W-1:0]  rf_wdata,
  output logic                    csr_we,
  output logic [13:0]             csr_addr,
  output logic [31:0]             csr_wmask,
  output logic [31:0]             csr_wdata,
  output logic                    ex_valid,
  output logic [7:0]              ex_ecode,
  output logic                    ex_esubcode,
  output logic [31:0]             ex_pc,
  output logic [31:0]             ex_vaddr,
  output logic [31:0]             pending_dest,
  output logic [32*RETIRE_W-1:0]  debug_wb_pc,
  output logic [4*RETIRE_W-1:0]   debug_wb_rf_we,
  output logic [5*RETIRE_W-1:0]   debug_wb_rf_wnum,
  output logic [32*RETIRE_W-1:0]  debug_wb_rf_wdata
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int POP_W = $clog2(RETIRE_W + 1);

  wb_entry_t                        in_ent;
  wb_entry_t [RETIRE_W-1:0]         head_ent;
  logic [DEPTH-1:0][GPR_IDX_W-1:0]  ent_dest;
  logic [DEPTH-1:0]                 ent_wr;
  logic [CNT_W-1:0]                 count;
  logic [RETIRE_W-1:0]              ret;
  logic                             ret0, ret1, enq, ex_fire;
  logic [POP_W-1:0]                 pop_n;
  logic                             ex_pending_q, ex_pending_d;

  assign in_ent = '{pc: in_if.in_pc, result: in_if.in_result, gr_we: in_if.in_gr_we,
                    dest: in_if.in_dest, vaddr: in_if.in_vaddr, ex: in_if.in_ex,
                    ecode: in_if.in_ecode, esubcode: in_if.in_esubcode,
                    csr_we: in_if.in_csr_we, csr_addr: in_if.in_csr_addr,
                    csr_wmask: in_if.in_csr_wmask, csr_wdata: in_if.in_csr_wdata};

  assign in_if.in_ready = !rst && (count < CNT_W'(DEPTH)) && !ex_pending_q && !flush;
  assign enq            = in_if.in_valid && in_if.in_ready;

  assign ret0 = !rst && !flush && !ex_pending_q && (count != '0);

  generate
    if (RETIRE_W > 1) begin : g_dual
      logic waw;
      // Same-cycle writes to one register would race in the RF; split them.
      assign waw  = head_ent[0].gr_we && head_ent[1].gr_we &&
                    (head_ent[0].dest == head_ent[1].dest) && (head_ent[0].dest != '0);
      assign ret1 = ret0 && (count >= CNT_W'(2)) && !head_ent[0].ex && !head_ent[0].csr_we &&
                    !head_ent[1].ex && !head_ent[1].csr_we && !waw;
      assign ret  = {ret1, ret0};
    end else begin : g_single
      assign ret1 = 1'b0;
      assign ret  = ret0;
    end
  endgenerate

  assign pop_n = POP_W'(ret0) + POP_W'(ret1);

  wb_queue #(.DEPTH(DEPTH), .RETIRE_W(RETIRE_W)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .enq      (enq),
    .enq_ent  (in_ent),
    .pop_n    (pop_n),
    .head_ent (head_ent),
    .ent_dest (ent_dest),
    .ent_wr   (ent_wr),
    .count    (count)
  );

  assign ex_fire = ret0 && head_ent[0].ex;

  always_comb begin
    ex_pending_d = ex_pending_q;
    if (ex_fire) ex_pending_d = 1'b1;
    if (flush)   ex_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) ex_pending_q <= 1'b0;
    else     ex_pending_q <= ex_pending_d;
  end

  assign ex_valid    = ex_fire;
  assign ex_ecode    = ex_fire ? head_ent[0].ecode    : '0;
  assign ex_esubcode = ex_fire ? head_ent[0].esubcode : 1'b0;
  assign ex_pc       = ex_fire ? head_ent[0].pc       : '0;
  assign ex_vaddr    = ex_fire ? head_ent[0].vaddr    : '0;

  assign csr_we    = ret0 && head_ent[0].csr_we && !head_ent[0].ex;
  assign csr_addr  = csr_we ? head_ent[0].csr_addr  : '0;
  assign csr_wmask = csr_we ? head_ent[0].csr_wmask : '0;
  assign csr_wdata = csr_we ? head_ent[0].csr_wdata : '0;

  generate
    for (genvar k = 0; k < RETIRE_W; k++) begin : g_slot
      assign rf_we[k]                     = ret[k] && head_ent[k].gr_we && !head_ent[k].ex;
      assign rf_waddr[k*5 +: 5]           = ret[k] ? head_ent[k].dest   : '0;
      assign rf_wdata[k*32 +: 32]         = ret[k] ? head_ent[k].result : '0;
      assign debug_wb_pc[k*32 +: 32]      = ret[k] ? head_ent[k].pc     : '0;
      assign debug_wb_rf_we[k*4 +: 4]     = {4{rf_we[k]}};
      assign debug_wb_rf_wnum[k*5 +: 5]   = rf_waddr[k*5 +: 5];
      assign debug_wb_rf_wdata[k*32 +: 32] = rf_wdata[k*32 +: 32];
      if (k > 0) begin : g_sink
        logic unused_slot;
        assign unused_slot = ^{head_ent[k].vaddr, head_ent[k].ecode, head_ent[k].esubcode,
                               head_ent[k].csr_addr, head_ent[k].csr_wmask, head_ent[k].csr_wdata};
      end
    end
  endgenerate

  always_comb begin
    pending_dest = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_wr[i]) pending_dest = pending_dest | dest_onehot(ent_dest[i]);
    pending_dest[0] = 1'b0;
    if (rst) pending_dest = '0;
  end
endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Parametrised writeback/commit stage for the in-order CPU pipeline, sitting between the memory stage and the register file / CSR unit. Buffers up to DEPTH completed instructions and retires them in program order, up to RETIRE_W per cycle. Serialises CSR writes and exceptions, and exports a pending-destination scoreboard to decode. Exceptions are reported once, then the queue holds until the CSR unit flushes the pipeline.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RETIRE_W, 2: maximum retirements per cycle; 1 or 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  memory stage holds a valid instruction.
- in_ready  out  1  stage allowin; enqueue when in_valid && in_ready.
- in_pc, in_result, in_vaddr  in  32 each  PC, final result, faulting virtual address.
- in_gr_we  in  1; in_dest  in  5  GPR write enable and index.
- in_ex  in  1; in_ecode  in  8; in_esubcode  in  1  exception flag and codes.
- in_csr_we  in  1; in_csr_addr  in  14; in_csr_wmask, in_csr_wdata  in  32 each  CSR write request.
- flush  in  1  CSR unit exception/ertn flush (ex_en).
- rf_we  out  RETIRE_W; rf_waddr  out  5*RETIRE_W; rf_wdata  out  32*RETIRE_W  per-slot GPR write; slot k occupies bits [k*w +: w].
- csr_we  out  1; csr_addr  out  14; csr_wmask, csr_wdata  out  32 each  CSR write, slot 0 only.
- ex_valid  out  1; ex_ecode  out  8; ex_esubcode  out  1; ex_pc, ex_vaddr  out  32 each  exception report.
- pending_dest  out  32  bit r set while an unretired, non-excepting entry writes GPR r.
- debug_wb_pc  out  32*RETIRE_W; debug_wb_rf_we  out  4*RETIRE_W; debug_wb_rf_wnum  out  5*RETIRE_W; debug_wb_rf_wdata  out  32*RETIRE_W  per-slot trace.

## Operation
- State: head and tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), ex_pending.
- in_ready = !rst && count < DEPTH && !ex_pending && !flush. When full, in_ready is 0 even in a retiring cycle.
- Slot 0 retires the head if count ≥ 1, !ex_pending and !flush.
- Head with ex: retires alone. ex_valid = 1 with head's ecode/esubcode/pc/vaddr. rf_we[0] = 0 and csr_we = 0. ex_pending is set next cycle.
- Head with csr_we (no ex): retires alone. csr_* outputs driven; rf_we[0] = gr_we.
- Slot 1 (RETIRE_W=2) retires head+1 only if all of the following hold:
  - count ≥ 2 and slot 0 retires;
  - neither entry has ex or csr_we;
  - NOT (both gr_we, same dest, and dest ≠ 0).
- rf_we[k] = slot k retires && gr_we && !ex. Writes to r0 pass through; the register file ignores them.
- count_next = count + enq − retired. head advances by retired; tail advances by enq.
- ex_pending holds retirement and enqueue off until flush.
- flush has priority over everything:
  - all retire outputs forced 0 that cycle;
  - next cycle count = 0, head = tail = 0, ex_pending = 0;
  - an enqueue offered in the flush cycle is dropped.
- pending_dest: OR over valid entries with gr_we && !ex of onehot(dest), bit 0 forced 0. Combinational from registered state.
- debug_wb_rf_we[k] = {4{rf_we[k]}; debug_wb_pc, wnum and wdata mirror the slot's entry.

## Timing
- Reset: while rst = 1 and on the cycle after, count = 0, ex_pending = 0, and all outputs are 0 (in_ready is 0 during rst, 1 after).
- Latency: entry enqueued at edge t is visible on retire outputs in cycle t+1. Retire outputs are combinational from the head entries.
- Throughput: 1 enqueue/cycle; up to RETIRE_W retirements/cycle.
- Enqueue and retire in the same cycle are legal, including at count = DEPTH−1 and across pointer wrap.
- ex_valid pulses for exactly one cycle per exception.
- rst asserted mid-operation discards all entries with no retire output.

## Structure
- Shared package wb_pkg: wb_entry_t struct (pc, result, gr_we, dest, vaddr, ex, ecode, esubcode, csr_we, csr_addr, csr_wmask, csr_wdata) and GPR/CSR width constants.
- One sub-module, wb_queue: storage, pointers, count, and multi-pop (0..RETIRE_W) of wb_entry_t.
- Retire selection, the scoreboard and the output mux stay in the top module.

## Test plan
- Back-to-back stream of 8 independent ALU results (dest 1..8), RETIRE_W=2 -> after fill, two rf writes per cycle, in order, rf_wdata matching; count never exceeds DEPTH.
- Two consecutive entries writing r5 (0x11, then 0x22) -> retired in separate cycles; final r5 = 0x22; pending_dest[5] clears only after the second.
- CSR entry (addr 0x006, wmask 0xFFFFFFFF, wdata 0xABCD) between two ALU ops -> CSR retires alone in slot 0 with csr_we = 1; neighbours do not share its cycle.
- Exception entry (ecode 0x0B, pc 0x1C000100) followed by 2 valid entries -> one-cycle ex_valid with those values; no rf_we; in_ready = 0 until flush; after flush, count = 0 and the 2 entries are never retired.
- Fill to DEPTH with in_valid held high -> in_ready = 0 while full; retire 2 / enqueue 1 across pointer wrap keeps order and data.
- rst and flush asserted mid-stream with an enqueue offered -> no outputs that cycle; queue empty next cycle; pending_dest = 0.
